// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: FSM encodings, handshake levels
// and the DIV/DIVU decode constants used by ID/EX.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // SPECIAL-opcode funct fields and internal ALU op codes
  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] FunctMult  = 6'b011000;
  localparam logic [5:0] FunctMultu = 6'b011001;
  localparam logic [5:0] FunctDiv   = 6'b011010;
  localparam logic [5:0] FunctDivu  = 6'b011011;

  localparam logic [7:0] AluOpNop   = 8'b00000000;
  localparam logic [7:0] AluOpMult  = 8'b00011000;
  localparam logic [7:0] AluOpMultu = 8'b00011001;
  localparam logic [7:0] AluOpDiv   = 8'b00011010;
  localparam logic [7:0] AluOpDivu  = 8'b00011011;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per clock.
// result = {remainder, quotient}; held while start stays high after ready.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  div_state_e         state_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   dividend_q;  // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH-1:0]   partial_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, diff;
  logic             qbit, last_iter;
  logic [WIDTH-1:0] partial_nx, quo_nx, quo_fix, rem_fix;

  assign abs_a = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign abs_b = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // WIDTH+1-bit compare/subtract keeps the carry when |divisor| has its MSB set
  assign shifted    = {partial_q, dividend_q[WIDTH-1]};
  assign diff       = shifted - {1'b0, divisor_q};
  assign qbit       = ~diff[WIDTH];
  assign partial_nx = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nx     = {dividend_q[WIDTH-2:0], qbit};
  assign quo_fix    = neg_quo_q ? -quo_nx : quo_nx;
  assign rem_fix    = neg_rem_q ? -partial_nx : partial_nx;
  assign last_iter  = (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      partial_q  <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      unique case (state_q)
        DivFree: begin
          if (start == DivStart && !annul) begin
            dividend_q <= abs_a;
            divisor_q  <= abs_b;
            partial_q  <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_rem_q  <= signed_div & opdata1[WIDTH-1];
            state_q    <= (opdata2 == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          result_q <= '0;
          ready_q  <= DivResultReady;
          state_q  <= DivEnd;
        end
        DivOn: begin
          if (annul) begin
            result_q <= '0;
            ready_q  <= DivResultNotReady;
            state_q  <= DivFree;
          end else begin
            dividend_q <= quo_nx;
            partial_q  <= partial_nx;
            cnt_q      <= cnt_q + 1'b1;
            if (last_iter) begin
              result_q <= {rem_fix, quo_fix};
              ready_q  <= DivResultReady;
              state_q  <= DivEnd;
            end
          end
        end
        DivEnd: begin
          if (start == DivStop) begin
            result_q <= '0;
            ready_q  <= DivResultNotReady;
            state_q  <= DivFree;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, signed_div, start, annul;
  logic [31:0] opdata1, opdata2;
  logic [63:0] result;
  logic        ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .signed_div(signed_div),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .start     (start),
    .annul     (annul),
    .result    (result),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Truncating division with 64-bit arithmetic so the signed overflow case is exact.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Presents an operation and returns just after edge E0; operands are then scrambled.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div = s;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    annul      = 1'b0;
    @(posedge clk);
    #1;
    opdata1    = $urandom;
    opdata2    = $urandom;
    signed_div = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ready(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic drop_start(input string name);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({name, " ready drop"}, {63'd0, ready}, 64'd0);
    check({name, " result clear"}, result, 64'd0);
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat, input string name);
    int lat;
    launch(s, a, b);
    wait_ready(lat);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check(name, result, exp);
    drop_start(name);
  endtask

  initial begin
    int lat;
    int highs;
    logic s;
    logic [31:0] a, b;

    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {63'd0, ready}, 64'd0);
    check("reset result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{1'b0, 32'h00000064, 32'h00000007, {32'h00000002, 32'h0000000E}, 32, "divu 100/7"});
    vecs.push_back('{1'b1, 32'hFFFFFFF9, 32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD}, 32, "div -7/2"});
    vecs.push_back('{1'b1, 32'h00000007, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 32, "div 7/-2"});
    vecs.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 32, "div overflow"});
    vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'h80000000, {32'h7FFFFFFF, 32'h00000001}, 32, "divu big divisor"});
    vecs.push_back('{1'b0, 32'h00000005, 32'h00000000, 64'd0, 1, "divu by zero"});
    vecs.push_back('{1'b1, 32'hFFFFFFF9, 32'h00000000, 64'd0, 1, "div by zero"});
    vecs.push_back('{1'b0, 32'h00000009, 32'h00000003, {32'h00000000, 32'h00000003}, 32, "divu 9/3"});
    foreach (vecs[i])
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

    // result and ready must hold while start stays high
    launch(1'b0, 32'd100, 32'd7);
    wait_ready(lat);
    check("hold latency", 64'(lat), 64'd32);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("hold ready", {63'd0, ready}, 64'd1);
      check("hold result", result, {32'd2, 32'd14});
    end
    drop_start("hold");

    // annul at E0+10 aborts silently
    launch(1'b0, 32'd9, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    annul = 1'b0;
    start = 1'b0;
    check("annul ready", {63'd0, ready}, 64'd0);
    check("annul result", result, 64'd0);
    highs = 0;
    for (int k = 0; k < 35; k++) begin
      @(posedge clk);
      #1;
      if (ready || result != 64'd0) highs++;
    end
    check("annul stays idle", 64'(highs), 64'd0);
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 32, "relaunch 9/3");

    // start with annul in FREE must not launch
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd5; opdata2 = 32'd0; start = 1'b1; annul = 1'b1;
    highs = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (ready) highs++;
    end
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    @(posedge clk);
    #1;
    if (ready) highs++;
    check("annul blocks launch", 64'(highs), 64'd0);

    // synchronous reset at E0+20
    launch(1'b1, 32'hFFFFFF00, 32'd7);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("midop reset ready", {63'd0, ready}, 64'd0);
    check("midop reset result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b1, 32'hFFFFFF00, 32'd7, model(1'b1, 32'hFFFFFF00, 32'd7), 32, "after reset");

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'hFFFFFFFF;
        4:       b = 32'h80000000 | $urandom;
        default: b = $urandom;
      endcase
      run_op(s, a, b, model(s, a, b), (b == 32'd0) ? 1 : 32, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle integer divider serving DIV/DIVU.
- Sits beside the execute stage and directly upstream of the HI/LO register write.
- EX asserts start and stalls the pipeline until ready. The 64-bit result is written to HI/LO through the normal MEM/WB path: remainder to HI, quotient to LO.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand width. result is 2*WIDTH; the iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1  in  WIDTH  dividend.
- opdata2  in  WIDTH  divisor.
- start  in  1  request; held high by EX until it sees ready.
- annul  in  1  abort the current operation (branch-delay/flush).
- result  out  2*WIDTH  {remainder, quotient}.
- ready  out  1  result valid.

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset, including mid-operation: state FREE, ready=0, result=0, counter=0, internal registers=0. No partial result is ever exposed.
- States: FREE, BY_ZERO, ON, END.
- FREE:
  - If start=1 and annul=0 at edge E0, latch operands:
    - |dividend| and |divisor| (negate only if signed_div=1 and the MSB is 1);
    - sign of quotient = signed_div & (a[31]^b[31]);
    - sign of remainder = signed_div & a[31].
  - If opdata2==0, go to BY_ZERO; otherwise go to ON with counter=0.
  - Otherwise remain in FREE.
- ON, one iteration per edge E0+1 … E0+WIDTH:
  - Shift the partial remainder left, inserting the next dividend bit (MSB first).
  - If partial ≥ |divisor|, subtract and set the quotient bit to 1; else set it to 0.
  - counter increments each iteration.
  - At the WIDTH-th iteration (edge E0+32):
    - apply sign fixes (two's-complement negate of quotient/remainder as latched);
    - register result, set ready=1, go to END.
- ON with annul=1 at any edge: go to FREE, ready stays 0, result=0.
- BY_ZERO: next edge (E0+1) goes to END with result=0, ready=1.
- END:
  - ready=1; result held stable while start=1 (annul ignored).
  - First edge with start=0: go to FREE, ready=0, result=0.
- Latency: ready high after E0+WIDTH (32 edges) for nonzero divisors; after E0+1 for a zero divisor.
- Operand changes after E0 are ignored.
- Truncating division: quotient rounds toward zero; remainder takes the dividend's sign.
- Overflow, signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, no exception.
- Subtraction uses a WIDTH+1-bit compare/subtract, so no carry is lost when |divisor| ≥ 0x80000000.
- start=1 with annul=1 in FREE: no launch.

Decomposition:
- Shared defines package:
  - state encodings DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END (2 bits);
  - DIV_RESULT_READY / DIV_RESULT_NOT_READY;
  - DIV_START / DIV_STOP;
  - opcode/funct constants for DIV/DIVU, alongside the existing ALU op defines.
- No sub-module. Negation and the compare/subtract are inline expressions.
- EX-side stall and HI/LO hookup live in their owning modules.

Test Plan:
1. DIVU 0x00000064 / 0x00000007, start held → ready=1 exactly after edge E0+32; result = {0x00000002, 0x0000000E}; ready=0 at edges E0+1…E0+31.
2. DIV 0xFFFFFFF9 / 0x00000002 → result = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 0x00000007 / 0xFFFFFFFE → result = {0x00000001, 0xFFFFFFFD}.
3. Boundary values:
   - DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
   - DIVU 0xFFFFFFFF / 0x80000000 → {0x7FFFFFFF, 0x00000001}.
4. DIVU 0x00000005 / 0x00000000 → ready=1 after E0+1, result=0. Drop start → next edge ready=0, state FREE.
5. DIVU 9/3, annul pulsed at E0+10 → ready never rises, result stays 0. Immediate relaunch with 9/3 → {0x00000000, 0x00000003} after 32 edges.
6. Ready/hold and reset:
   - Keep start high 5 edges after ready → result and ready stable.
   - Assert rst at E0+20 of a new operation → next edge ready=0, result=0, state FREE; the following start completes normally.
